multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Sequencing controller for the CPU datapath in a multi-cycle configuration.
//  Steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
//  Handshakes with instruction memory and drives the datapath enables.
//  Decodes the R-format (0110011) and I-format addi (0010011) classes.
//  Sits between the instruction register / instruction memory and the PC, register file and ALU control.
// PARAMETERS
//  FETCH_TIMEOUT  16  max FETCH cycles without IMemAck_i before trapping (>=1)
//  CNT_W          32  width of retired-instruction counter
// PORTS
//  clk_i         in   1      clock; single clock domain
//  rst_i         in   1      reset; asynchronous, active-high
//  start_i       in   1      run enable; level-sensitive
//  Op_i          in   7      opcode field from the instruction memory output
//  IMemAck_i     in   1      instruction memory data valid
//  IMemReq_o     out  1      instruction fetch request
//  IRWrite_o     out  1      load instruction register
//  PCWrite_o     out  1      advance PC
//  ALUOp_o       out  2      ALU control class: 10 = R-format, 00 = add
//  ALUSrc_o      out  1      0 = rs2, 1 = immediate
//  RegWrite_o    out  1      register file write enable
//  Busy_o        out  1      controller mid-instruction
//  Trap_o        out  1      sticky error: illegal opcode or fetch timeout
//  RetireCnt_o   out  CNT_W  instructions completed; wraps at 2^CNT_W
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; op_q=0; timer=0; RetireCnt_o=0.
//    While in reset, every output is 0, including ALUOp_o=00.
//  - Output timing: Moore style. Outputs are a function of the state register and op_q only.
//    Op_i and IMemAck_i never reach an output combinationally, except IRWrite_o (see FETCH).
//  - IDLE: all enables are 0. If start_i=1, go to FETCH.
//  - FETCH: IMemReq_o=1.
//    - IMemAck_i=1: IRWrite_o=1 in that same cycle; go to DECODE.
//    - Timer clears on entry to FETCH and increments on each FETCH cycle without ack.
//    - No ack in FETCH_TIMEOUT consecutive cycles: go to TRAP.
//    - Ack in the last allowed cycle wins over the timeout.
//    - IMemAck_i is ignored in every other state.
//  - DECODE: op_q <= Op_i.
//    - Op_i is 0110011 or 0010011: go to EXECUTE.
//    - Any other opcode: go to TRAP.
//  - EXECUTE: drive ALU controls from op_q; go to WRITEBACK.
//    - R-format: ALUOp_o=10, ALUSrc_o=0.
//    - addi: ALUOp_o=00, ALUSrc_o=1.
//  - WRITEBACK: ALUOp_o and ALUSrc_o held as in EXECUTE; RegWrite_o=1 and PCWrite_o=1 for exactly one cycle.
//    - RetireCnt_o increments by 1 (wraps from all-ones to 0).
//    - Next state: FETCH if start_i=1, otherwise IDLE.
//  - TRAP: Trap_o=1; all enables 0; absorbing state, left only by rst_i.
//  - start_i=0 mid-instruction: current instruction completes through WRITEBACK, then IDLE.
//    There is no abort path.
//  - Busy_o=1 in FETCH, DECODE, EXECUTE and WRITEBACK; 0 in IDLE and TRAP.
//  - Latency: 4 cycles per instruction with zero-wait memory.
//    With zero-wait memory and start_i held, PCWrite_o pulses every 4th cycle.
//  - ALUOp_o and ALUSrc_o are 0 in IDLE, FETCH, DECODE and TRAP.
// STRUCTURE
//  - ctrl_pkg holds:
//    - OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011
//    - ALUOP_R=2'b10, ALUOP_ADD=2'b00
//    - state enum {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP}
//  - Sub-module fetch_timer: counter of width $clog2(FETCH_TIMEOUT+1).
//    Ports: clear, enable, expired.
//  - Everything else (state register, op_q, retire counter, output decode) is inline.
// TESTING
//  1. Reset mid-run: assert rst_i during EXECUTE of an addi.
//     -> All outputs 0 immediately, before the next clock edge; RetireCnt_o=0.
//     -> After release with start_i=1, FETCH follows on the next edge.
//  2. Zero-wait R-format: start_i=1, IMemAck_i=1, Op_i=0110011.
//     -> IRWrite_o at cycle 1; ALUOp_o=10, ALUSrc_o=0 at cycle 3.
//     -> RegWrite_o and PCWrite_o at cycle 4; RetireCnt_o=1 at cycle 5.
//  3. Back-to-back addi x3 with start_i held: PCWrite_o pulses at cycles 4, 8 and 12.
//     -> ALUOp_o=00 and ALUSrc_o=1 during each EXECUTE and WRITEBACK; RetireCnt_o=3.
//  4. Fetch wait: FETCH_TIMEOUT=4.
//     -> Ack on the 4th FETCH cycle: proceeds to DECODE, Trap_o=0.
//     -> No ack for 4 cycles: Trap_o=1 and Busy_o=0, held until rst_i.
//  5. Illegal opcode: Op_i=0000011 at DECODE.
//     -> Trap_o=1 next cycle; RegWrite_o and PCWrite_o never asserted; RetireCnt_o unchanged.
//  6. Stop and wrap: drop start_i during DECODE.
//     -> Instruction retires, then IDLE with Busy_o=0.
//     -> With CNT_W=2, four retirements return RetireCnt_o to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU classes and FSM states shared by the multi-cycle controller
package ctrl_pkg;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP} state_t;
    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ITYPE);
    endfunction
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts FETCH cycles without an ack; expired marks the last allowed cycle
//   clk, rst : clock, async active-high reset
//   clear    : force count to zero (held while not fetching)
//   enable   : count one waited cycle
//   expired  : current cycle is the TIMEOUT-th consecutive wait cycle
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end
    assign expired = cnt >= LAST;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/WRITEBACK sequencer for a multi-cycle datapath
//   clk_i, rst_i  : clock, async active-high reset
//   start_i       : run enable (level)
//   Op_i          : opcode from instruction memory
//   IMemAck_i     : instruction memory data valid
//   IMemReq_o     : fetch request
//   IRWrite_o     : load instruction register (combinational on ack in FETCH)
//   PCWrite_o     : advance PC
//   ALUOp_o       : 10 = R-format, 00 = add
//   ALUSrc_o      : 0 = rs2, 1 = immediate
//   RegWrite_o    : register file write
//   Busy_o        : mid-instruction
//   Trap_o        : sticky illegal-opcode / fetch-timeout flag
//   RetireCnt_o   : retired instruction count, wrapping
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       Op_i,
    input  logic             IMemAck_i,
    output logic             IMemReq_o,
    output logic             IRWrite_o,
    output logic             PCWrite_o,
    output logic [1:0]       ALUOp_o,
    output logic             ALUSrc_o,
    output logic             RegWrite_o,
    output logic             Busy_o,
    output logic             Trap_o,
    output logic [CNT_W-1:0] RetireCnt_o
);
    state_t state, next_state;
    logic [6:0] op_q;
    logic [CNT_W-1:0] retire_q;
    logic expired;
    logic alu_phase;
    fetch_timer #(.TIMEOUT(FETCH_TIMEOUT)) u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (state != FETCH),
        .enable  (state == FETCH && !IMemAck_i),
        .expired (expired)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            op_q     <= '0;
            retire_q <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE) op_q <= Op_i;
            if (state == WRITEBACK) retire_q <= retire_q + 1'b1;
        end
    end
    // An ack in the final allowed cycle takes priority over the timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = start_i ? FETCH : IDLE;
            FETCH:     next_state = IMemAck_i ? DECODE : (expired ? TRAP : FETCH);
            DECODE:    next_state = op_legal(Op_i) ? EXECUTE : TRAP;
            EXECUTE:   next_state = WRITEBACK;
            WRITEBACK: next_state = start_i ? FETCH : IDLE;
            default:   next_state = TRAP;
        endcase
    end
    assign alu_phase   = (state == EXECUTE) || (state == WRITEBACK);
    assign IMemReq_o   = state == FETCH;
    assign IRWrite_o   = (state == FETCH) && IMemAck_i;
    assign PCWrite_o   = state == WRITEBACK;
    assign RegWrite_o  = state == WRITEBACK;
    assign ALUOp_o     = (alu_phase && op_q == OP_RTYPE) ? ALUOP_R : ALUOP_ADD;
    assign ALUSrc_o    = alu_phase && op_q == OP_ITYPE;
    assign Busy_o      = (state == FETCH) || (state == DECODE) || alu_phase;
    assign Trap_o      = state == TRAP;
    assign RetireCnt_o = retire_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table, directed and random checks against an instruction-level model
module tb_multicycle_control;
    localparam int FT = 4;
    localparam int CW = 2;
    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ack = 1'b0;
    logic [6:0] op = '0;
    logic req, irw, pcw, alusrc, regw, busy, trap;
    logic [1:0] aluop;
    logic [CW-1:0] rc;
    int n_chk = 0;
    int n_fail = 0;
    multicycle_control #(.FETCH_TIMEOUT(FT), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .Op_i(op), .IMemAck_i(ack),
        .IMemReq_o(req), .IRWrite_o(irw), .PCWrite_o(pcw), .ALUOp_o(aluop),
        .ALUSrc_o(alusrc), .RegWrite_o(regw), .Busy_o(busy), .Trap_o(trap),
        .RetireCnt_o(rc)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: step within the current instruction (0 idle, 1..4 = cycle of instruction, -1 trapped),
    // wait cycles spent fetching, total retired, opcode of the instruction in flight.
    int m_step_n, m_wait, m_ret;
    logic [6:0] m_op;
    task automatic m_reset();
        m_step_n = 0; m_wait = 0; m_ret = 0; m_op = '0;
    endtask
    task automatic m_clock();
        if (m_step_n == 0) begin
            if (start) begin m_step_n = 1; m_wait = 0; end
        end else if (m_step_n == 1) begin
            if (ack) m_step_n = 2;
            else begin
                m_wait++;
                if (m_wait == FT) m_step_n = -1;
            end
        end else if (m_step_n == 2) begin
            m_op = op;
            m_step_n = (op == R_OP || op == I_OP) ? 3 : -1;
        end else if (m_step_n == 3) m_step_n = 4;
        else if (m_step_n == 4) begin
            m_ret++;
            m_step_n = start ? 1 : 0;
            m_wait = 0;
        end
    endtask
    task automatic check_model(input string tag);
        logic alu;
        alu = (m_step_n == 3) || (m_step_n == 4);
        chk({tag, ".req"},    32'(req),    32'(m_step_n == 1));
        chk({tag, ".irw"},    32'(irw),    32'(m_step_n == 1 && ack));
        chk({tag, ".pcw"},    32'(pcw),    32'(m_step_n == 4));
        chk({tag, ".regw"},   32'(regw),   32'(m_step_n == 4));
        chk({tag, ".aluop"},  32'(aluop),  (alu && m_op == R_OP) ? 32'd2 : 32'd0);
        chk({tag, ".alusrc"}, 32'(alusrc), 32'(alu && m_op == I_OP));
        chk({tag, ".busy"},   32'(busy),   32'(m_step_n > 0));
        chk({tag, ".trap"},   32'(trap),   32'(m_step_n < 0));
        chk({tag, ".rc"},     32'(rc),     32'(m_ret % (1 << CW)));
    endtask
    task automatic tick(input logic s, input logic a, input logic [6:0] o, input string tag);
        @(negedge clk);
        start = s; ack = a; op = o;
        #1 check_model(tag);
        @(posedge clk);
        m_clock();
    endtask
    // Caller positions this just after a negedge; reset is pulsed asynchronously mid-cycle.
    task automatic do_reset(input logic s, input logic a, input logic [6:0] o);
        start = s; ack = a; op = o;
        rst = 1'b1;
        #1 m_reset();
        check_model("reset");
        #2 rst = 1'b0;
        @(posedge clk);
        m_clock();
    endtask
    typedef struct {
        logic s, a;
        logic [6:0] o;
        logic irw, pcw, rw, src, bsy;
        logic [1:0] aop, cnt;
    } vec_t;
    vec_t tbl[6];
    initial begin
        logic [31:0] pmask;
        tbl[0] = '{1'b1, 1'b1, R_OP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        tbl[1] = '{1'b1, 1'b1, R_OP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[2] = '{1'b1, 1'b0, R_OP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
        tbl[3] = '{1'b1, 1'b1, I_OP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
        tbl[4] = '{1'b0, 1'b1, I_OP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0};
        tbl[5] = '{1'b0, 1'b1, R_OP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
        #2;
        @(negedge clk);
        do_reset(1'b0, 1'b0, '0);
        // zero-wait R-format from IDLE
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = tbl[i].s; ack = tbl[i].a; op = tbl[i].o;
            #1;
            chk($sformatf("tbl%0d.irw", i), 32'(irw), 32'(tbl[i].irw));
            chk($sformatf("tbl%0d.pcw", i), 32'(pcw), 32'(tbl[i].pcw));
            chk($sformatf("tbl%0d.regw", i), 32'(regw), 32'(tbl[i].rw));
            chk($sformatf("tbl%0d.alusrc", i), 32'(alusrc), 32'(tbl[i].src));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("tbl%0d.aluop", i), 32'(aluop), 32'(tbl[i].aop));
            chk($sformatf("tbl%0d.rc", i), 32'(rc), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.trap", i), 32'(trap), 32'd0);
        end
        // reset in EXECUTE of an addi, then restart
        @(negedge clk);
        #1 do_reset(1'b1, 1'b1, I_OP);
        tick(1'b1, 1'b1, I_OP, "rm_fetch");
        tick(1'b1, 1'b0, I_OP, "rm_decode");
        @(negedge clk);
        #1 chk("rm_pre.alusrc", 32'(alusrc), 32'd1);
        do_reset(1'b1, 1'b1, I_OP);
        chk("rm_zero.all", {25'd0, req, irw, pcw, aluop, alusrc, regw, busy, trap, rc}, 32'd0);
        tick(1'b1, 1'b1, I_OP, "rm_after");
        chk("rm_after.req", 32'(m_step_n), 32'd2);
        // three back-to-back addi
        @(negedge clk);
        #1 do_reset(1'b1, 1'b1, I_OP);
        pmask = '0;
        m_ret = 0;
        for (int c = 1; c <= 12; c++) begin
            tick(1'b1, 1'b1, I_OP, "b2b");
            if (pcw) pmask |= 32'(1) << c;
        end
        chk("b2b.pcw_cycles", pmask, (32'(1) << 4) | (32'(1) << 8) | (32'(1) << 12));
        @(negedge clk);
        #1 chk("b2b.rc", 32'(rc), 32'd3);
        // fetch wait: ack on last allowed cycle, then a full timeout
        do_reset(1'b1, 1'b0, R_OP);
        for (int w = 0; w < FT - 1; w++) tick(1'b1, 1'b0, R_OP, "fw_wait");
        tick(1'b1, 1'b1, R_OP, "fw_ack");
        tick(1'b1, 1'b0, R_OP, "fw_decode");
        tick(1'b1, 1'b0, R_OP, "fw_exec");
        tick(1'b1, 1'b0, R_OP, "fw_wb");
        for (int w = 0; w < FT; w++) tick(1'b1, 1'b0, R_OP, "to_wait");
        for (int w = 0; w < 5; w++) tick(1'($urandom), 1'($urandom), 7'($urandom), "to_held");
        @(negedge clk);
        #1 chk("to.trap", 32'(trap), 32'd1);
        chk("to.busy", 32'(busy), 32'd0);
        // illegal opcode at DECODE
        do_reset(1'b1, 1'b1, R_OP);
        tick(1'b1, 1'b1, R_OP, "il_fetch");
        tick(1'b1, 1'b0, 7'b0000011, "il_decode");
        for (int w = 0; w < 4; w++) tick(1'b1, 1'b1, I_OP, "il_held");
        @(negedge clk);
        #1 chk("il.trap", 32'(trap), 32'd1);
        chk("il.rc", 32'(rc), 32'd0);
        // stop during DECODE, four times, counter wraps
        do_reset(1'b1, 1'b1, I_OP);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick(1'b1, 1'b1, I_OP, "sw_idle");
            tick(1'b1, 1'b1, I_OP, "sw_fetch");
            tick(1'b0, 1'b1, I_OP, "sw_decode");
            tick(1'b0, 1'b1, I_OP, "sw_exec");
            tick(1'b0, 1'b1, I_OP, "sw_wb");
            tick(1'b0, 1'b1, I_OP, "sw_stop");
        end
        @(negedge clk);
        #1 chk("sw.rc_wrap", 32'(rc), 32'd0);
        chk("sw.busy", 32'(busy), 32'd0);
        // random traffic
        do_reset(1'b0, 1'b0, '0);
        for (int c = 0; c < 600; c++) begin
            int r;
            logic [6:0] o;
            r = int'($urandom_range(0, 9));
            o = r < 4 ? R_OP : (r < 8 ? I_OP : 7'($urandom));
            if (m_step_n < 0 && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                #1 do_reset(1'b1, 1'b0, o);
            end else tick($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, o, "rand");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
